// File: rtl/pair_product_scan_if.sv
// Signal bundle for pair_product_scan: caller-side generator handshake plus the
// source-side channel. master = environment driving the block, slave = the block.
interface pair_product_scan_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] n;
  logic             ready;
  logic             valid;
  logic             done;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] src_n;
  logic             src_start;
  logic             src_ready;
  logic             src_valid;
  logic             src_done;
  logic [WIDTH-1:0] src_out0;
  logic [WIDTH-1:0] src_out1;

  modport master (
    output start, n, ready, src_valid, src_done, src_out0, src_out1,
    input  valid, done, out0, out1, src_n, src_start, src_ready
  );

  modport slave (
    input  start, n, ready, src_valid, src_done, src_out0, src_out1,
    output valid, done, out0, out1, src_n, src_start, src_ready
  );
endinterface

// File: rtl/pair_product_scan.sv
// Generator consumer: pulls (a, b) pairs from a source, accumulates sum(a*b) and
// yields (sum, count) every STRIDE pairs plus a final partial when the source ends.
module pair_product_scan #(
  parameter int WIDTH  = 32,
  parameter int STRIDE = 4
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic [WIDTH-1:0] n,
  input  logic             _ready,
  output logic             _valid,
  output logic             _done,
  output logic [WIDTH-1:0] _out0,
  output logic [WIDTH-1:0] _out1,
  output logic [WIDTH-1:0] _src_n,
  output logic             _src_start,
  output logic             _src_ready,
  input  logic             _src_valid,
  input  logic             _src_done,
  input  logic [WIDTH-1:0] _src_out0,
  input  logic [WIDTH-1:0] _src_out1
);

  localparam int unsigned PW = $clog2(STRIDE + 1);

  typedef enum logic [1:0] {IDLE, PULL, DONE} state_e;

  state_e           state_q;
  logic             valid_q, done_q, src_start_q;
  logic [WIDTH-1:0] out0_q, out1_q, src_n_q;
  logic [WIDTH-1:0] acc_q, cnt_q, acc_d, cnt_d;
  logic [PW-1:0]    phase_q, phase_d, phase_inc;
  logic [WIDTH-1:0] product_c;
  logic             advance_c, src_ready_c, accept_c, full_c, finish_c, partial_c;

  // Accept/emit decisions for this cycle; nothing moves while a result is stalled.
  always_comb begin
    advance_c   = _ready || !valid_q;
    src_ready_c = (state_q == PULL) && advance_c && !src_start_q;
    accept_c    = _src_valid && src_ready_c;
    product_c   = WIDTH'($signed(_src_out0) * $signed(_src_out1));
    phase_inc   = phase_q + PW'(1);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    full_c      = 1'b0;
    if (accept_c) begin
      acc_d = acc_q + product_c;
      cnt_d = cnt_q + WIDTH'(1);
      if (phase_inc == PW'(STRIDE)) begin
        full_c  = 1'b1;
        phase_d = '0;
      end else begin
        phase_d = phase_inc;
      end
    end
    // A stale done from the previous run is ignored during the launch cycle.
    finish_c  = src_ready_c && _src_done;
    partial_c = finish_c && (phase_d != '0);
  end

  always_ff @(posedge _clock) begin
    if (_start) begin
      state_q     <= PULL;
      src_n_q     <= n;
      src_start_q <= 1'b1;
      acc_q       <= '0;
      cnt_q       <= '0;
      phase_q     <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else if (_reset) begin
      state_q     <= IDLE;
      src_n_q     <= '0;
      src_start_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      phase_q     <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
    end else begin
      done_q      <= 1'b0;
      src_start_q <= 1'b0;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      if (_ready) valid_q <= 1'b0;
      if (full_c || partial_c) begin
        out0_q  <= acc_d;
        out1_q  <= cnt_d;
        valid_q <= 1'b1;
      end
      case (state_q)
        PULL: if (finish_c) state_q <= DONE;
        DONE: begin
          // Finish only once the last result has been taken by the caller.
          if (!valid_q && _ready) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign _valid     = valid_q;
  assign _done      = done_q;
  assign _out0      = out0_q;
  assign _out1      = out1_q;
  assign _src_n     = src_n_q;
  assign _src_start = src_start_q;
  assign _src_ready = src_ready_c;

endmodule

// File: tb/tb_pair_product_scan.sv
// Directed bench for pair_product_scan: hrange-style source model, result
// scoreboard and stall/restart/reset sequences on STRIDE=4 and STRIDE=2 instances.
module tb_pair_product_scan;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  pair_product_scan_if #(.WIDTH(W)) a_if ();
  pair_product_scan_if #(.WIDTH(W)) b_if ();

  pair_product_scan #(.WIDTH(W), .STRIDE(4)) dut4 (
    ._clock(clk), ._reset(rst), ._start(a_if.start), .n(a_if.n), ._ready(a_if.ready),
    ._valid(a_if.valid), ._done(a_if.done), ._out0(a_if.out0), ._out1(a_if.out1),
    ._src_n(a_if.src_n), ._src_start(a_if.src_start), ._src_ready(a_if.src_ready),
    ._src_valid(a_if.src_valid), ._src_done(a_if.src_done),
    ._src_out0(a_if.src_out0), ._src_out1(a_if.src_out1)
  );

  pair_product_scan #(.WIDTH(W), .STRIDE(2)) dut2 (
    ._clock(clk), ._reset(rst), ._start(b_if.start), .n(b_if.n), ._ready(b_if.ready),
    ._valid(b_if.valid), ._done(b_if.done), ._out0(b_if.out0), ._out1(b_if.out1),
    ._src_n(b_if.src_n), ._src_start(b_if.src_start), ._src_ready(b_if.src_ready),
    ._src_valid(b_if.src_valid), ._src_done(b_if.src_done),
    ._src_out0(b_if.src_out0), ._src_out1(b_if.src_out1)
  );

  // Shared source: hrange (a=b=i, i<n) or a custom pair table; sel picks the consumer.
  logic          custom = 1'b0;
  logic [W-1:0]  clen = '0;
  logic [W-1:0]  pa [4];
  logic [W-1:0]  pb [4];
  logic          s_act = 1'b0;
  logic [W-1:0]  s_idx = '0;
  logic [W-1:0]  s_len, s_a, s_b;
  logic          s_valid, s_done, s_start, s_rdy;

  assign s_start = sel ? b_if.src_start : a_if.src_start;
  assign s_rdy   = sel ? b_if.src_ready : a_if.src_ready;
  assign s_len   = custom ? clen : (sel ? b_if.src_n : a_if.src_n);
  assign s_valid = s_act && (s_idx < s_len);
  assign s_done  = s_act && (s_idx >= s_len);
  assign s_a     = custom ? pa[s_idx[1:0]] : s_idx;
  assign s_b     = custom ? pb[s_idx[1:0]] : s_idx;

  assign a_if.ready = ready;     assign b_if.ready = ready;
  assign a_if.src_valid = s_valid; assign b_if.src_valid = s_valid;
  assign a_if.src_done = s_done;   assign b_if.src_done = s_done;
  assign a_if.src_out0 = s_a;      assign b_if.src_out0 = s_a;
  assign a_if.src_out1 = s_b;      assign b_if.src_out1 = s_b;

  always @(posedge clk) begin
    if (s_start) begin
      s_idx <= '0;
      s_act <= 1'b1;
    end else if (s_valid && s_rdy) begin
      s_idx <= s_idx + 1;
    end
  end

  // Scoreboard of the selected instance, sampled on the falling edge.
  logic [W-1:0] m_out0, m_out1;
  logic         m_valid, m_done;
  assign m_valid = sel ? b_if.valid : a_if.valid;
  assign m_done  = sel ? b_if.done  : a_if.done;
  assign m_out0  = sel ? b_if.out0  : a_if.out0;
  assign m_out1  = sel ? b_if.out1  : a_if.out1;

  logic [W-1:0] rq0 [$];
  logic [W-1:0] rq1 [$];
  int done_cnt = 0;
  int acc_cnt = 0;
  bit valid_seen = 1'b0;

  always @(negedge clk) begin
    if (m_valid) valid_seen = 1'b1;
    if (m_valid && ready) begin
      rq0.push_back(m_out0);
      rq1.push_back(m_out1);
    end
    if (m_done) done_cnt++;
    if (s_valid && s_rdy) acc_cnt++;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    rq0.delete();
    rq1.delete();
    done_cnt = 0;
    acc_cnt = 0;
    valid_seen = 1'b0;
  endtask

  task automatic pulse_start(input logic use_b, input logic [W-1:0] nv);
    if (use_b) begin b_if.start = 1'b1; b_if.n = nv; end
    else       begin a_if.start = 1'b1; a_if.n = nv; end
    tick();
    a_if.start = 1'b0;
    b_if.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) begin ok = 1'b1; break; end
      tick();
    end
    chk({nm, "_done_seen"}, W'(ok), W'(1));
    for (int i = 0; i < 4; i++) tick();
    chk({nm, "_done_pulses"}, W'(done_cnt), W'(1));
  endtask

  typedef struct packed {
    logic [W-1:0]        n;
    logic [W-1:0]        nres;
    logic [2:0][W-1:0]   e0;
    logic [2:0][W-1:0]   e1;
  } vec_t;

  vec_t vt [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.start = 1'b0; a_if.n = '0;
    b_if.start = 1'b0; b_if.n = '0;
    pa[0] = 32'h7FFF_FFFF; pb[0] = 32'h1;
    pa[1] = 32'h1;         pb[1] = 32'h1;
    pa[2] = 32'h0001_0000; pb[2] = 32'h0001_0000;
    pa[3] = 32'h0;         pb[3] = 32'h0;

    vt[0] = '{n: 32'd10, nres: 32'd3, e0: {32'd285, 32'd140, 32'd14}, e1: {32'd10, 32'd8, 32'd4}};
    vt[1] = '{n: 32'd8,  nres: 32'd2, e0: {32'd0,   32'd140, 32'd14}, e1: {32'd0,  32'd8, 32'd4}};
    vt[2] = '{n: 32'd0,  nres: 32'd0, e0: {32'd0,   32'd0,   32'd0},  e1: {32'd0,  32'd0, 32'd0}};
    vt[3] = '{n: 32'd1,  nres: 32'd1, e0: {32'd0,   32'd0,   32'd0},  e1: {32'd0,  32'd0, 32'd1}};
    vt[4] = '{n: 32'd5,  nres: 32'd2, e0: {32'd0,   32'd30,  32'd14}, e1: {32'd0,  32'd5, 32'd4}};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", W'(a_if.valid), W'(0));
    chk("rst_done", W'(a_if.done), W'(0));
    chk("rst_out0", a_if.out0, W'(0));
    chk("rst_out1", a_if.out1, W'(0));
    chk("rst_src_n", a_if.src_n, W'(0));
    chk("rst_src_start", W'(a_if.src_start), W'(0));
    chk("rst_src_ready", W'(a_if.src_ready), W'(0));
    tick();

    // Table-driven hrange runs with the caller always ready
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clr();
      pulse_start(1'b0, vt[i].n);
      wait_done($sformatf("v%0d", i), 400);
      chk($sformatf("v%0d_nres", i), W'(rq0.size()), vt[i].nres);
      for (int k = 0; k < 3; k++) begin
        if (k < rq0.size()) begin
          chk($sformatf("v%0d_out0_%0d", i, k), rq0[k], vt[i].e0[k]);
          chk($sformatf("v%0d_out1_%0d", i, k), rq1[k], vt[i].e1[k]);
        end
      end
      chk($sformatf("v%0d_accepts", i), W'(acc_cnt), vt[i].n);
      if (vt[i].nres == 0) chk($sformatf("v%0d_valid_never", i), W'(valid_seen), W'(0));
    end

    // Caller stall while the first result is held
    clr();
    ready = 1'b0;
    pulse_start(1'b0, 32'd10);
    begin
      bit up;
      up = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (a_if.valid) begin up = 1'b1; break; end
        tick();
      end
      chk("stall_valid_up", W'(up), W'(1));
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall_out0_c%0d", c), a_if.out0, W'(14));
      chk($sformatf("stall_out1_c%0d", c), a_if.out1, W'(4));
      chk($sformatf("stall_src_ready_c%0d", c), W'(a_if.src_ready), W'(0));
      chk($sformatf("stall_valid_c%0d", c), W'(a_if.valid), W'(1));
    end
    tick();
    ready = 1'b1;
    wait_done("stall", 400);
    chk("stall_nres", W'(rq0.size()), W'(3));
    if (rq0.size() == 3) begin
      chk("stall_r0_out0", rq0[0], W'(14));
      chk("stall_r0_out1", rq1[0], W'(4));
      chk("stall_r1_out0", rq0[1], W'(140));
      chk("stall_r2_out0", rq0[2], W'(285));
      chk("stall_r2_out1", rq1[2], W'(10));
    end

    // STRIDE=2 instance: signed wrap and truncated product
    sel = 1'b1;
    custom = 1'b1;
    clen = 32'd4;
    clr();
    pulse_start(1'b1, 32'd4);
    wait_done("s2", 400);
    chk("s2_nres", W'(rq0.size()), W'(2));
    if (rq0.size() == 2) begin
      chk("s2_r0_out0", rq0[0], 32'h8000_0000);
      chk("s2_r0_out1", rq1[0], W'(2));
      chk("s2_r1_out0", rq0[1], 32'h8000_0000);
      chk("s2_r1_out1", rq1[1], W'(4));
    end
    custom = 1'b0;
    sel = 1'b0;
    tick();

    // Mid-stream restart with a shorter range
    clr();
    pulse_start(1'b0, 32'd10);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (rq0.size() >= 1) begin got = 1'b1; break; end
        tick();
      end
      chk("rs_first_result", W'(got), W'(1));
    end
    clr();
    a_if.start = 1'b1;
    a_if.n = 32'd4;
    tick();
    a_if.start = 1'b0;
    @(negedge clk);
    chk("rs_src_start", W'(a_if.src_start), W'(1));
    chk("rs_src_n", a_if.src_n, W'(4));
    chk("rs_valid_cleared", W'(a_if.valid), W'(0));
    tick();
    wait_done("rs", 400);
    chk("rs_nres", W'(rq0.size()), W'(1));
    if (rq0.size() == 1) begin
      chk("rs_out0", rq0[0], W'(14));
      chk("rs_out1", rq1[0], W'(4));
    end

    // Synchronous reset in the middle of a run
    clr();
    pulse_start(1'b0, 32'd10);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_valid", W'(a_if.valid), W'(0));
    chk("mr_src_ready", W'(a_if.src_ready), W'(0));
    chk("mr_out0", a_if.out0, W'(0));
    begin
      int snap;
      snap = acc_cnt;
      for (int i = 0; i < 40; i++) tick();
      chk("mr_no_done", W'(done_cnt), W'(0));
      chk("mr_no_results", W'(rq0.size()), W'(0));
      chk("mr_no_accepts", W'(acc_cnt), W'(snap));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
